maxpool_window_g3s2: RTL

MAXPOOL_WINDOW_G3S2 -- requirements
Module: maxpool_window_g3s2

---
 rtl/maxpool_window_g3s2_pkg.sv | 17 +
 rtl/maxpool_window_g3s2_if.sv | 28 ++
 rtl/maxpool_window_g3s2_lane_max3.sv | 24 ++
 rtl/maxpool_window_g3s2.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/maxpool_window_g3s2_pkg.sv
// Shared constants and helpers for the 3x3 / stride-2 max-pool window.
// Lanes are unsigned post-ReLU values packed LSB-first into one pixel word.
package maxpool_pkg;

  localparam int unsigned LANE_W = 9;
  localparam int unsigned LANES  = 3;

  function automatic bit size_is_even(input int unsigned size);
    return (size % 2) == 0;
  endfunction

  // Lanes are zero-extended to 32 bits by the caller, so the compare is unsigned.
  function automatic logic [31:0] lane_max(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_window_g3s2_if.sv
// Pixel-stream bundle for the max-pool window: three row taps in, pooled pixels out.
interface maxpool_window_g3s2_if #(
  parameter int unsigned WIDTH_D = 27
);

  logic               i_vsync;
  logic               i_hsync;
  logic               i_valid;
  logic [WIDTH_D-1:0] i_tdata_r0;
  logic [WIDTH_D-1:0] i_tdata_r1;
  logic [WIDTH_D-1:0] i_tdata_r2;
  logic               o_vsync;
  logic               o_hsync;
  logic               o_valid;
  logic [WIDTH_D-1:0] o_tdata;
  logic               o_ovf;

  modport master (
    output i_vsync, i_hsync, i_valid, i_tdata_r0, i_tdata_r1, i_tdata_r2,
    input  o_vsync, o_hsync, o_valid, o_tdata, o_ovf
  );

  modport slave (
    input  i_vsync, i_hsync, i_valid, i_tdata_r0, i_tdata_r1, i_tdata_r2,
    output o_vsync, o_hsync, o_valid, o_tdata, o_ovf
  );

endinterface

// File: rtl/maxpool_window_g3s2_lane_max3.sv
// Combinational 3-input per-lane unsigned maximum over a packed pixel word.
module maxpool_lane_max3 #(
  parameter int unsigned WIDTH_D = 27,
  parameter int unsigned LANE_W  = 9
) (
  input  logic [WIDTH_D-1:0] i_a,
  input  logic [WIDTH_D-1:0] i_b,
  input  logic [WIDTH_D-1:0] i_c,
  output logic [WIDTH_D-1:0] o_max
);
  import maxpool_pkg::*;

  localparam int unsigned NLANE = WIDTH_D / LANE_W;

  always_comb begin
    o_max = '0;
    for (int l = 0; l < NLANE; l++) begin
      o_max[l*LANE_W +: LANE_W] = LANE_W'(lane_max(
          lane_max(32'(i_a[l*LANE_W +: LANE_W]), 32'(i_b[l*LANE_W +: LANE_W])),
          32'(i_c[l*LANE_W +: LANE_W])));
    end
  end

endmodule

// File: rtl/maxpool_window_g3s2.sv
// 3x3 max-pool, stride 2, zero padding 1: vertical max in stage 1, horizontal max in stage 2.
// Outputs appear only for odd row / odd column anchors, two cycles after the anchor beat.
module maxpool_window_g3s2 #(
  parameter int unsigned WIDTH_D = maxpool_pkg::LANE_W * maxpool_pkg::LANES,
  parameter int unsigned LANE_W  = maxpool_pkg::LANE_W,
  parameter int unsigned SIZE    = 14
) (
  input logic                 i_sclk,
  input logic                 i_rst_n,
  maxpool_window_g3s2_if.slave bus
);
  import maxpool_pkg::*;

  localparam int unsigned CW = $clog2(SIZE + 1);

  if (!size_is_even(SIZE)) begin : g_size_odd
    $error("maxpool_window_g3s2: SIZE must be even");
  end

  logic               r_vs_prev;
  logic               r_hs_prev;
  logic               r_active;
  logic [CW-1:0]      r_col;
  logic [CW-1:0]      r_row;
  logic [WIDTH_D-1:0] r_v;
  logic [WIDTH_D-1:0] r_h1;
  logic [WIDTH_D-1:0] r_h2;
  logic               r_s1_valid;
  logic               r_s1_first;
  logic               r_s1_fire;
  logic               r_hs_d1;
  logic               r_o_vsync;
  logic               r_o_hsync;
  logic               r_o_valid;
  logic [WIDTH_D-1:0] r_o_tdata;
  logic               r_o_ovf;

  logic               w_vs_rise;
  logic               w_hs_rise;
  logic               w_hs_fall;
  logic [CW-1:0]      w_col;
  logic [CW-1:0]      w_row;
  logic               w_beat;
  logic               w_col_ovf;
  logic               w_row_ovf;
  logic               w_in_range;
  logic               w_fire;
  logic [WIDTH_D-1:0] w_v_max;
  logic [WIDTH_D-1:0] w_win_max;

  assign w_vs_rise = bus.i_vsync & ~r_vs_prev;
  assign w_hs_rise = bus.i_hsync & ~r_hs_prev;
  assign w_hs_fall = ~bus.i_hsync & r_hs_prev;

  // Position of the beat presented this cycle, with same-cycle frame/row starts applied.
  assign w_col      = (w_vs_rise || w_hs_rise) ? '0 : r_col;
  assign w_row      = w_vs_rise ? '0 : r_row;
  assign w_beat     = bus.i_valid & (r_active | w_vs_rise);
  assign w_col_ovf  = (w_col == CW'(SIZE));
  assign w_row_ovf  = (w_row >= CW'(SIZE));
  assign w_in_range = w_beat & ~w_col_ovf & ~w_row_ovf;
  assign w_fire     = w_in_range & w_col[0] & w_row[0];

  maxpool_lane_max3 #(
    .WIDTH_D (WIDTH_D),
    .LANE_W  (LANE_W)
  ) u_stage1_max (
    .i_a   (bus.i_tdata_r0),
    .i_b   (bus.i_tdata_r1),
    .i_c   (bus.i_tdata_r2),
    .o_max (w_v_max)
  );

  maxpool_lane_max3 #(
    .WIDTH_D (WIDTH_D),
    .LANE_W  (LANE_W)
  ) u_stage2_max (
    .i_a   (r_v),
    .i_b   (r_h1),
    .i_c   (r_h2),
    .o_max (w_win_max)
  );

  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      r_vs_prev  <= 1'b0;
      r_hs_prev  <= 1'b0;
      r_active   <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_v        <= '0;
      r_h1       <= '0;
      r_h2       <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_fire  <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_o_vsync  <= 1'b0;
      r_o_hsync  <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_tdata  <= '0;
      r_o_ovf    <= 1'b0;
    end else begin
      r_vs_prev <= bus.i_vsync;
      r_hs_prev <= bus.i_hsync;
      r_o_vsync <= r_vs_prev;
      r_hs_d1   <= bus.i_hsync & w_row[0];
      r_o_hsync <= r_hs_d1;

      if (w_vs_rise) r_active <= 1'b1;

      // Stage 1: vertical max of the three taps.
      r_v        <= bus.i_valid ? w_v_max : '0;
      r_s1_valid <= w_in_range;
      r_s1_first <= (w_col == '0);
      r_s1_fire  <= w_fire;

      // Column saturates at SIZE on an overlong row.
      r_col <= (w_beat && !w_col_ovf) ? w_col + CW'(1) : w_col;

      if (w_hs_fall && !w_vs_rise && (r_row != CW'(SIZE))) r_row <= r_row + CW'(1);
      else                                                 r_row <= w_row;

      r_o_ovf <= w_vs_rise ? 1'b0 : (r_o_ovf | (w_beat & (w_col_ovf | w_row_ovf)));

      // Column 0 seeds H2 with the left padding column for the col-1 window.
      if (w_vs_rise) begin
        r_h1 <= '0;
        r_h2 <= '0;
      end else if (r_s1_valid) begin
        r_h1 <= r_v;
        r_h2 <= r_s1_first ? '0 : r_h1;
      end else if (w_hs_rise) begin
        r_h1 <= '0;
        r_h2 <= '0;
      end

      // Stage 2: horizontal max; a frame restart drops the in-flight window.
      r_o_valid <= r_s1_fire & ~w_vs_rise;
      if (r_s1_fire && !w_vs_rise) r_o_tdata <= w_win_max;
    end
  end

  assign bus.o_vsync = r_o_vsync;
  assign bus.o_hsync = r_o_hsync;
  assign bus.o_valid = r_o_valid;
  assign bus.o_tdata = r_o_tdata;
  assign bus.o_ovf   = r_o_ovf;

endmodule
